command_sender: RTL

//  Downstream of the command sequencer. Takes a 3-bit command index plus a start level and streams
//  the matching ASCII command string, byte by byte, into the byte-wide UART transmitter.

---
 rtl/command_sender_pkg.sv | 49 ++++
 rtl/command_sender_if.sv | 9 +
 rtl/command_sender_rom.sv | 29 ++
 rtl/command_sender.sv | 103 ++++++++++
 4 files changed

// File: rtl/command_sender_pkg.sv
// Shared definitions for command_sender: FSM states, line-ending bytes,
// ROM geometry and the command string/length tables.
package cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_ACK,
        S_DRAIN,
        S_NEXT,
        S_FIN
    } state_t;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    localparam int ROM_DEPTH = 8;
    localparam int ROM_WIDTH = 16;
    localparam int ROM_BITS  = ROM_WIDTH * 8;
    localparam int ROM_LEN_W = 7;

    // Strings are right-justified: the last character sits in bits [7:0].
    localparam logic [ROM_BITS-1:0] STR_0 = ROM_BITS'("AT");
    localparam logic [ROM_BITS-1:0] STR_1 = ROM_BITS'("AT+RST");
    localparam logic [ROM_BITS-1:0] STR_2 = ROM_BITS'("AT+CWMODE=1");
    localparam logic [ROM_BITS-1:0] STR_3 = ROM_BITS'("AT+CIPMUX=0");

    function automatic logic [ROM_BITS-1:0] rom_str(input logic [2:0] cmd);
        case (cmd)
            3'd0:    rom_str = STR_0;
            3'd1:    rom_str = STR_1;
            3'd2:    rom_str = STR_2;
            3'd3:    rom_str = STR_3;
            default: rom_str = '0;
        endcase
    endfunction

    function automatic logic [ROM_LEN_W-1:0] rom_len(input logic [2:0] cmd);
        case (cmd)
            3'd0:    rom_len = 7'd2;
            3'd1:    rom_len = 7'd6;
            3'd2:    rom_len = 7'd11;
            3'd3:    rom_len = 7'd11;
            default: rom_len = 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/command_sender_if.sv
// Byte-wide link between command_sender (master) and the UART transmitter (slave).
interface command_sender_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (output tx_data, output tx_start, input tx_busy);
    modport slave  (input tx_data, input tx_start, output tx_busy);
endinterface

// File: rtl/command_sender_rom.sv
// Combinational command ROM: (cmd, idx) -> character byte and string length.
// Bytes at or beyond the string length read as 0.
module cmd_rom
    import cmd_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic [2:0]           cmd,
    input  logic [IDX_W-1:0]     idx,
    output logic [7:0]           data,
    output logic [ROM_LEN_W-1:0] len
);

    logic [ROM_BITS-1:0]  str;
    logic [ROM_LEN_W-1:0] pos;

    // Pick the string, then shift the requested character down to the low byte.
    always_comb begin
        str  = rom_str(cmd);
        len  = rom_len(cmd);
        pos  = '0;
        data = 8'h00;
        if (ROM_LEN_W'(idx) < len) begin
            pos  = len - ROM_LEN_W'(idx) - ROM_LEN_W'(1);
            data = 8'(str >> {pos, 3'b000});
        end
    end

endmodule

// File: rtl/command_sender.sv
// command_sender: streams the ASCII string selected by command_1 into a
// byte-wide UART, one tx_start pulse per byte, handshaking on tx_busy.
// Optional build macro CMD_CRLF_EN appends CR LF after every string.
module command_sender
    import cmd_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int ACK_TO  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       command_1,
    input  logic             start,
    output logic             ready_command,
    command_sender_if.master uart
);

    localparam int IDX_W = $clog2(MAX_LEN + 3);
    localparam int TMR_W = $clog2(ACK_TO + 1);

    state_t           state, state_n;
    logic [2:0]       cmd_q, last_cmd;
    logic             start_q;
    logic [IDX_W-1:0] idx;
    logic [TMR_W-1:0] tmr;

    logic [7:0]           rom_data;
    logic [ROM_LEN_W-1:0] rom_len_w;
    logic [7:0]           idx_ext, len_ext, eff_len, byte_sel;
    logic                 launch;

    cmd_rom #(.IDX_W(IDX_W)) u_rom (
        .cmd  (cmd_q),
        .idx  (idx),
        .data (rom_data),
        .len  (rom_len_w)
    );

    assign idx_ext = 8'(idx);
    assign len_ext = 8'(rom_len_w);
    assign launch  = start && (!start_q || (command_1 != last_cmd));
    assign ready_command = (state == S_IDLE);

`ifdef CMD_CRLF_EN
    assign eff_len  = len_ext + 8'd2;
    assign byte_sel = (idx_ext < len_ext)  ? rom_data :
                      (idx_ext == len_ext) ? CR : LF;
`else
    assign eff_len  = len_ext;
    assign byte_sel = rom_data;
`endif

    // State, launch capture, byte index and ack timeout down-counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cmd_q    <= '0;
            last_cmd <= '0;
            start_q  <= 1'b0;
            idx      <= '0;
            tmr      <= '0;
        end else begin
            state   <= state_n;
            start_q <= start;
            if (state == S_IDLE && launch) begin
                cmd_q    <= command_1;
                last_cmd <= command_1;
                idx      <= '0;
            end
            if (state == S_SEND)
                tmr <= TMR_W'(ACK_TO);
            else if (state == S_ACK && tmr != '0)
                tmr <= tmr - TMR_W'(1);
            if (state == S_NEXT)
                idx <= idx + IDX_W'(1);
        end
    end

    // Next-state decode and UART strobe generation.
    always_comb begin
        state_n       = state;
        uart.tx_start = 1'b0;
        uart.tx_data  = 8'h00;
        case (state)
            S_IDLE:  if (launch) state_n = S_LOAD;
            S_LOAD:  state_n = (idx_ext < eff_len) ? S_SEND : S_FIN;
            S_SEND: begin
                uart.tx_start = 1'b1;
                uart.tx_data  = byte_sel;
                state_n       = S_ACK;
            end
            S_ACK: begin
                if (uart.tx_busy)    state_n = S_DRAIN;
                else if (tmr == '0)  state_n = S_NEXT;
            end
            S_DRAIN: if (!uart.tx_busy) state_n = S_NEXT;
            S_NEXT:  state_n = S_LOAD;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

endmodule
